alu_writeback_queue: RTL and testbench
======================================

// Module: alu_writeback_queue
// PURPOSE
//  Receiving end of the ALU result interface. Buffers 32-bit results from the
//  logic/arith units (nor, and, add, ...) with a valid/ready handshake.
//  Drains them into the single register-file write port when the regfile
//  arbiter grants it. Also offers a forwarding lookup over pending results,
//  so decode can bypass values not yet written.
// PARAMETERS
//  DATA_W  32  result / register data width
//  ADDR_W  5   register index width (32 architectural regs, r0 hardwired 0)
//  DEPTH   4   queue entries; power of 2, >= 2
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous pipeline flush (branch/exception)
//  in_valid   in   1       ALU result valid
//  in_ready   out  1       queue can accept (= !full)
//  in_rd      in   ADDR_W  destination register
//  in_result  in   DATA_W  ALU result
//  rf_req     out  1       queue non-empty, requesting write port
//  rf_grant   in   1       arbiter grants write port this cycle
//  rf_we      out  1       regfile write enable (= rf_req & rf_grant & !flush)
//  rf_waddr   out  ADDR_W  head entry register index
//  rf_wdata   out  DATA_W  head entry data
//  lk_addr    in   ADDR_W  forwarding lookup register index
//  lk_hit     out  1       a pending entry targets lk_addr
//  lk_data    out  DATA_W  data of youngest matching entry (0 if !lk_hit)
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - rd/wr pointers, count and all entry valid bits clear.
//   - Outputs: rf_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, lk_hit=0,
//     lk_data=0, count=0, in_ready=1.
//  Occupancy states, derived from count:
//   - EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
//   - push only: EMPTY->PARTIAL; PARTIAL->PARTIAL|FULL.
//   - pop only: FULL->PARTIAL; PARTIAL->PARTIAL|EMPTY.
//   - push+pop: state unchanged.
//   - flush: any state -> EMPTY.
//  Push: accepted on in_valid & in_ready & !flush. Entry written at wr_ptr;
//   wr_ptr wraps mod DEPTH. Results with in_rd==0 complete the handshake but
//   are discarded (no enqueue, count unchanged).
//  Pop: on rf_we; rd_ptr advances and wraps mod DEPTH.
//   rf_waddr/rf_wdata are driven combinationally from the head entry,
//   and are 0 when EMPTY.
//  Latency: result accepted in cycle N is visible at head no earlier than
//   N+1. There is no bypass from input to regfile port.
//  FULL: in_ready=0 even if a pop occurs in the same cycle (no pass-through).
//  Simultaneous push+pop in PARTIAL: both take effect, count unchanged.
//  Ordering: strict FIFO. Multiple entries to the same rd are written in
//   arrival order.
//  flush (sync, highest priority below reset):
//   - all entries invalidated, pointers and count to 0.
//   - same-cycle push dropped; rf_we forced 0.
//  Lookup (combinational):
//   - lk_hit=1 iff some valid entry has rd==lk_addr and lk_addr!=0.
//   - lk_data is taken from the youngest such entry (closest to wr_ptr).
//  Reset asserted mid-drain: queue contents lost, and no rf_we is issued
//   while rst_n is low.
// STRUCTURE
//  Package riscv_alu_pkg:
//   - DATA_W and REG_ADDR_W constants.
//   - wb_entry_t struct {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}.
//  Sub-module fwd_lookup:
//   - DEPTH-way comparator plus youngest-first priority select.
//   - Inputs: entry array, valid bits, wr_ptr, lk_addr.
//  Pointer/count logic and the storage array stay in the top module.
// TESTING
//  1. Push (rd=3, 0xFFFF0000) to empty queue, rf_grant=1
//     -> rf_req next cycle; rf_we with waddr=3, wdata=0xFFFF0000; count 1->0.
//  2. Push 4 entries with rf_grant=0
//     -> count=4, in_ready=0; a 5th in_valid is held off.
//     Then grant=1: 4 writes in push order; in_ready=1 after the first pop.
//  3. Push rd=7 0x1, then rd=7 0x2, lk_addr=7
//     -> lk_hit=1, lk_data=0x2.
//     lk_addr=0 -> lk_hit=0, lk_data=0.
//  4. Push rd=0 0xDEADBEEF -> handshake completes, count stays 0, no rf_we.
//  5. Three entries pending, flush pulsed with in_valid=1 and rf_grant=1
//     -> no rf_we that cycle; count=0 next cycle; the pushed entry is absent.
//  6. rst_n dropped asynchronously while count=2 mid-drain
//     -> all outputs reach reset values immediately; in_ready=1; after
//        release, push/pop resume from pointer 0 with wrap-around checked
//        over 10 entries.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_alu_pkg
//  Description : Shared widths, writeback entry record and occupancy codes
//                for the ALU writeback path.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_alu_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   localparam logic [1:0] OCC_EMPTY   = 2'd0;
   localparam logic [1:0] OCC_PARTIAL = 2'd1;
   localparam logic [1:0] OCC_FULL    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fwd_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_lookup
//  Description : DEPTH-way register-index compare over pending writeback
//                entries; returns data of the youngest valid match.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_lookup
   import riscv_alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wb_entry_t [DEPTH-1:0]         i_entries,
   input  logic      [DEPTH-1:0]         i_valid,
   input  logic      [$clog2(DEPTH)-1:0] i_wr_ptr,
   input  logic      [REG_ADDR_W-1:0]    i_lk_addr,
   output logic                          o_hit,
   output logic      [DATA_W-1:0]        o_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] w_idx;

   // Walk oldest (wr_ptr - DEPTH == wr_ptr) to youngest (wr_ptr - 1); later
   // matches overwrite earlier ones, so the youngest match wins.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         w_idx = i_wr_ptr - PTR_W'(k);
         if (i_valid[w_idx] && (i_entries[w_idx].rd == i_lk_addr) &&
             (i_lk_addr != '0)) begin
            o_hit  = 1'b1;
            o_data = i_entries[w_idx].data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_queue
//  Description : FIFO of ALU results draining into the register-file write
//                port, with a forwarding lookup over pending entries.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_writeback_queue #(
   parameter int DATA_W = riscv_alu_pkg::DATA_W,
   parameter int ADDR_W = riscv_alu_pkg::REG_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_rd,
   input  logic [DATA_W-1:0]        in_result,
   output logic                     rf_req,
   input  logic                     rf_grant,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   input  logic [ADDR_W-1:0]        lk_addr,
   output logic                     lk_hit,
   output logic [DATA_W-1:0]        lk_data,
   output logic [$clog2(DEPTH):0]   count
);

   import riscv_alu_pkg::*;

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]  C_DEPTH = (PTR_W+1)'(DEPTH);

   wb_entry_t [DEPTH-1:0] r_mem;
   logic      [DEPTH-1:0] r_valid;
   logic      [PTR_W-1:0] r_wr_ptr;
   logic      [PTR_W-1:0] r_rd_ptr;
   logic      [PTR_W:0]   r_count;

   logic [1:0] w_occ;
   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   wb_entry_t  w_head;

   always_comb begin
      if (r_count == '0)
         w_occ = OCC_EMPTY;
      else if (r_count == C_DEPTH)
         w_occ = OCC_FULL;
      else
         w_occ = OCC_PARTIAL;
   end

   assign w_full   = (w_occ == OCC_FULL);
   assign w_empty  = (w_occ == OCC_EMPTY);
   assign in_ready = ~w_full;

   // Writes to r0 complete the handshake but never occupy a slot.
   assign w_push   = in_valid & ~w_full & ~flush & (in_rd != '0);
   assign rf_req   = ~w_empty;
   assign w_pop    = rf_req & rf_grant & ~flush;
   assign rf_we    = w_pop;

   assign w_head   = r_mem[r_rd_ptr];
   assign rf_waddr = w_empty ? '0 : w_head.rd;
   assign rf_wdata = w_empty ? '0 : w_head.data;
   assign count    = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         // Push and pop never address the same slot: a push needs !full,
         // and wr_ptr == rd_ptr with entries present means full.
         if (w_push) begin
            r_wr_ptr          <= r_wr_ptr + 1'b1;
            r_valid[r_wr_ptr] <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr          <= r_rd_ptr + 1'b1;
            r_valid[r_rd_ptr] <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy is tracked by r_valid/r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{rd: in_rd, data: in_result};
      end
   end

   fwd_lookup #(
      .DEPTH (DEPTH)
   ) u_fwd_lookup (
      .i_entries (r_mem),
      .i_valid   (r_valid),
      .i_wr_ptr  (r_wr_ptr),
      .i_lk_addr (lk_addr),
      .o_hit     (lk_hit),
      .o_data    (lk_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback_queue
//  Description : Directed vector bench for alu_writeback_queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_writeback_queue;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic        rf_req;
   logic        rf_grant;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  lk_addr;
   logic        lk_hit;
   logic [31:0] lk_data;
   logic [2:0]  count;

   alu_writeback_queue #(
      .DATA_W (32),
      .ADDR_W (5),
      .DEPTH  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rd     (in_rd),
      .in_result (in_result),
      .rf_req    (rf_req),
      .rf_grant  (rf_grant),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .lk_addr   (lk_addr),
      .lk_hit    (lk_hit),
      .lk_data   (lk_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        gnt;
      logic [4:0]  lk;
      logic        rdy;
      logic        req;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        hit;
      logic [31:0] ld;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic void add(input int fl, input int iv, input int rd,
                               input logic [31:0] res, input int gnt,
                               input int lk, input int rdy, input int req,
                               input int we, input int wa,
                               input logic [31:0] wd, input int hit,
                               input logic [31:0] ld, input int cnt);
      vec_t v;
      v.fl = 1'(fl);   v.iv = 1'(iv);   v.rd = 5'(rd);  v.res = res;
      v.gnt = 1'(gnt); v.lk = 5'(lk);   v.rdy = 1'(rdy); v.req = 1'(req);
      v.we = 1'(we);   v.wa = 5'(wa);   v.wd = wd;      v.hit = 1'(hit);
      v.ld = ld;       v.cnt = 3'(cnt);
      vq.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return 128'({in_ready, rf_req, rf_we, rf_waddr, rf_wdata,
                   lk_hit, lk_data, count});
   endfunction

   task automatic drive(input logic fl, input logic iv, input logic [4:0] rd,
                        input logic [31:0] res, input logic gnt,
                        input logic [4:0] lk);
      flush = fl; in_valid = iv; in_rd = rd; in_result = res;
      rf_grant = gnt; lk_addr = lk;
   endtask

   localparam logic [127:0] C_RESET_OUTS = 128'({1'b1, 1'b0, 1'b0, 5'd0,
                                             32'd0, 1'b0, 32'd0, 3'd0});

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0]  mq_rd[$];
      logic [31:0] mq_d[$];
      int          sent;
      logic        e_rdy, e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 check("reset_state", outs(), C_RESET_OUTS);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // fl iv rd res gnt lk | rdy req we wa wd hit ld cnt
      add(0,1, 3,'hFFFF0000,1, 0, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,0, 0,'h0,       1, 3, 1,1,1, 3,'hFFFF0000,1,'hFFFF0000,1);
      add(0,0, 0,'h0,       0, 3, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,1, 1,'h11,      0, 0, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,1, 2,'h22,      0, 0, 1,1,0, 1,'h11,      0,'h0,       1);
      add(0,1, 3,'h33,      0, 0, 1,1,0, 1,'h11,      0,'h0,       2);
      add(0,1, 4,'h44,      0, 0, 1,1,0, 1,'h11,      0,'h0,       3);
      add(0,1, 5,'h55,      0, 4, 0,1,0, 1,'h11,      1,'h44,      4);
      add(0,1, 5,'h55,      1, 4, 0,1,1, 1,'h11,      1,'h44,      4);
      add(0,1, 5,'h55,      1, 0, 1,1,1, 2,'h22,      0,'h0,       3);
      add(0,0, 0,'h0,       1, 0, 1,1,1, 3,'h33,      0,'h0,       3);
      add(0,0, 0,'h0,       1, 0, 1,1,1, 4,'h44,      0,'h0,       2);
      add(0,0, 0,'h0,       1, 5, 1,1,1, 5,'h55,      1,'h55,      1);
      add(0,0, 0,'h0,       0, 5, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,1, 7,'h1,       0, 7, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,1, 7,'h2,       0, 7, 1,1,0, 7,'h1,       1,'h1,       1);
      add(0,0, 0,'h0,       0, 7, 1,1,0, 7,'h1,       1,'h2,       2);
      add(0,0, 0,'h0,       0, 0, 1,1,0, 7,'h1,       0,'h0,       2);
      add(0,1, 0,'hDEADBEEF,0, 0, 1,1,0, 7,'h1,       0,'h0,       2);
      add(0,0, 0,'h0,       1, 0, 1,1,1, 7,'h1,       0,'h0,       2);
      add(0,0, 0,'h0,       1, 7, 1,1,1, 7,'h2,       1,'h2,       1);
      add(0,1, 0,'hDEADBEEF,1, 0, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,0, 0,'h0,       1, 0, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,1, 8,'h80,      0, 0, 1,0,0, 0,'h0,       0,'h0,       0);
      add(0,1, 9,'h90,      0, 0, 1,1,0, 8,'h80,      0,'h0,       1);
      add(0,1,10,'hA0,      0,10, 1,1,0, 8,'h80,      0,'h0,       2);
      add(1,1,11,'hB0,      1,10, 1,1,0, 8,'h80,      1,'hA0,      3);
      add(0,0, 0,'h0,       1,11, 1,0,0, 0,'h0,       0,'h0,       0);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].fl, vq[i].iv, vq[i].rd, vq[i].res, vq[i].gnt, vq[i].lk);
         #1;
         check($sformatf("vec%0d", i), outs(),
               128'({vq[i].rdy, vq[i].req, vq[i].we, vq[i].wa, vq[i].wd,
                     vq[i].hit, vq[i].ld, vq[i].cnt}));
      end

      // Asynchronous reset in the middle of a drain with two entries pending.
      @(negedge clk); drive(1'b0, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd12);
      @(negedge clk); drive(1'b0, 1'b1, 5'd13, 32'hD0, 1'b0, 5'd12);
      @(negedge clk); drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
      #1 check("pre_reset_drain", 128'({rf_we, rf_waddr, rf_wdata, count}),
               128'({1'b1, 5'd12, 32'hC0, 3'd2}));
      #1 rst_n = 1'b0;
      #1 check("async_reset_outs", outs(), C_RESET_OUTS);
      in_valid = 1'b1; in_rd = 5'd14;
      @(posedge clk);
      #1 check("reset_held_no_we", outs(), C_RESET_OUTS);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      // Ten entries through a reference FIFO with a stuttering grant.
      sent = 0;
      for (int cyc = 0; cyc < 60 && (sent < 10 || mq_rd.size() > 0); cyc++) begin
         @(negedge clk);
         drive(1'b0, (sent < 10), 5'(sent + 1), 32'h1000 + 32'(sent),
               (cyc % 3 != 2), 5'd0);
         #1;
         e_rdy = (mq_rd.size() < 4);
         e_we  = rf_grant && (mq_rd.size() > 0);
         e_wa  = (mq_rd.size() > 0) ? mq_rd[0] : 5'd0;
         e_wd  = (mq_d.size() > 0) ? mq_d[0] : 32'd0;
         check($sformatf("wrap_c%0d", cyc),
               128'({in_ready, rf_we, rf_waddr, rf_wdata, count}),
               128'({e_rdy, e_we, e_wa, e_wd, 3'(mq_rd.size())}));
         if (e_we) begin
            void'(mq_rd.pop_front());
            void'(mq_d.pop_front());
         end
         if (in_valid && e_rdy) begin
            mq_rd.push_back(in_rd);
            mq_d.push_back(in_result);
            sent++;
         end
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1 check("wrap_drained", 128'({rf_req, count, 4'(sent)}),
               128'({1'b0, 3'd0, 4'd10}));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
